// File: rtl/csa_pkg.sv
// Shared definitions for the CSA stream sequencer: packed stream-state layout and key mapping.
package csa_pkg;

    localparam int unsigned ST_W  = 107;
    localparam int unsigned AB_W  = 40;
    localparam int unsigned NIB_W = 4;

    // Field offsets of {A[39:0],B[39:0],D,E,F,X,Y,Z[3:0],p,q,r}
    localparam int unsigned A_LSB = 67;
    localparam int unsigned B_LSB = 27;
    localparam int unsigned D_LSB = 23;
    localparam int unsigned E_LSB = 19;
    localparam int unsigned F_LSB = 15;
    localparam int unsigned X_LSB = 11;
    localparam int unsigned Y_LSB = 7;
    localparam int unsigned Z_LSB = 3;
    localparam int unsigned P_BIT = 2;
    localparam int unsigned Q_BIT = 1;
    localparam int unsigned R_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT_RUN,
        ST_GEN_RUN,
        ST_OUT
    } csa_fsm_e;

    // Common key into the initial stream state; A and B get nibble 0 at the LSB.
    function automatic logic [ST_W-1:0] key_to_state(input logic [63:0] ck);
        logic [ST_W-1:0] s;
        s[A_LSB +: AB_W]  = {8'h00, ck[31:0]};
        s[B_LSB +: AB_W]  = {8'h00, ck[63:32]};
        s[D_LSB +: NIB_W] = '0;
        s[E_LSB +: NIB_W] = '0;
        s[F_LSB +: NIB_W] = '0;
        s[X_LSB +: NIB_W] = '0;
        s[Y_LSB +: NIB_W] = '0;
        s[Z_LSB +: NIB_W] = '0;
        s[P_BIT]          = 1'b0;
        s[Q_BIT]          = 1'b0;
        s[R_BIT]          = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/csa_stream_ctrl.sv
// Sequencer in front of the 8-byte stream-cipher pipeline: key load, init/generation passes,
// state feedback between blocks of a packet and one keystream word out per block.
module csa_stream_ctrl
    import csa_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ck_valid,
    input  logic [63:0]     ck,
    input  logic            blk_valid,
    output logic            blk_ready,
    input  logic [63:0]     blk_data,
    input  logic            blk_first,
    input  logic            blk_last,
    output logic            sa_init,
    output logic [63:0]     sa_sb,
    output logic [ST_W-1:0] sa_state,
    input  logic [ST_W-1:0] so_state,
    input  logic [63:0]     so_cb,
    output logic            ks_valid,
    input  logic            ks_ready,
    output logic [63:0]     ks_data,
    output logic            ks_last
);

    localparam int unsigned CNT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    if (PIPE_LAT == 0) begin : g_bad_pipe_lat
        $error("csa_stream_ctrl: PIPE_LAT must be at least 1");
    end

    csa_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ST_W-1:0]  key_q, key_d;
    logic [ST_W-1:0]  saved_q, saved_d;
    logic             key_loaded_q, key_loaded_d;
    logic             active_q, active_d;
    logic             last_q, last_d;
    logic             sa_init_d;
    logic [63:0]      sa_sb_d;
    logic [ST_W-1:0]  sa_state_d;
    logic             ks_valid_d;
    logic [63:0]      ks_data_d;
    logic             ks_last_d;

    // A key load in the same cycle as an offered block takes priority.
    assign blk_ready = rst_n && (state_q == ST_IDLE) && key_loaded_q && !ck_valid;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        saved_d      = saved_q;
        key_loaded_d = key_loaded_q;
        active_d     = active_q;
        last_d       = last_q;
        sa_init_d    = 1'b0;
        sa_sb_d      = sa_sb;
        sa_state_d   = sa_state;
        ks_valid_d   = ks_valid;
        ks_data_d    = ks_data;
        ks_last_d    = ks_last;

        case (state_q)
            ST_IDLE: begin
                if (ck_valid) begin
                    key_d        = key_to_state(ck);
                    key_loaded_d = 1'b1;
                    active_d     = 1'b0;
                end else if (blk_valid && blk_ready) begin
                    last_d = blk_last;
                    cnt_d  = CNT_W'(PIPE_LAT);
                    if (blk_first || !active_q) begin
                        state_d    = ST_INIT_RUN;
                        sa_init_d  = 1'b1;
                        sa_sb_d    = blk_data;
                        sa_state_d = key_q;
                    end else begin
                        state_d    = ST_GEN_RUN;
                        sa_sb_d    = '0;
                        sa_state_d = saved_q;
                    end
                end
            end
            ST_INIT_RUN: begin
                sa_init_d = 1'b1;
                if (cnt_q == '0) begin
                    // Keystream of the init pass is dropped; only the state carries on.
                    saved_d    = so_state;
                    state_d    = ST_GEN_RUN;
                    sa_init_d  = 1'b0;
                    sa_sb_d    = '0;
                    sa_state_d = so_state;
                    cnt_d      = CNT_W'(PIPE_LAT);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GEN_RUN: begin
                if (cnt_q == '0) begin
                    saved_d    = so_state;
                    ks_data_d  = so_cb;
                    ks_last_d  = last_q;
                    ks_valid_d = 1'b1;
                    active_d   = 1'b1;
                    state_d    = ST_OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (ks_ready) begin
                    ks_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                    if (ks_last) begin
                        active_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            key_q        <= '0;
            saved_q      <= '0;
            key_loaded_q <= 1'b0;
            active_q     <= 1'b0;
            last_q       <= 1'b0;
            sa_init      <= 1'b0;
            sa_sb        <= '0;
            sa_state     <= '0;
            ks_valid     <= 1'b0;
            ks_data      <= '0;
            ks_last      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            saved_q      <= saved_d;
            key_loaded_q <= key_loaded_d;
            active_q     <= active_d;
            last_q       <= last_d;
            sa_init      <= sa_init_d;
            sa_sb        <= sa_sb_d;
            sa_state     <= sa_state_d;
            ks_valid     <= ks_valid_d;
            ks_data      <= ks_data_d;
            ks_last      <= ks_last_d;
        end
    end

endmodule

// File: tb/tb_csa_stream_ctrl.sv
// Scoreboard bench for csa_stream_ctrl with a stub pipeline (state+1, cb=state[63:0]^A5..).
`timescale 1ns/1ps
module tb_csa_stream_ctrl;
    import csa_pkg::*;

    localparam int L = 10;
    localparam logic [63:0] CB_MASK = 64'hA5A5_A5A5_A5A5_A5A5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ck_valid;
    logic [63:0]     ck;
    logic            blk_valid;
    logic            blk_ready;
    logic [63:0]     blk_data;
    logic            blk_first;
    logic            blk_last;
    logic            sa_init;
    logic [63:0]     sa_sb;
    logic [ST_W-1:0] sa_state;
    logic [ST_W-1:0] so_state;
    logic [63:0]     so_cb;
    logic            ks_valid;
    logic            ks_ready;
    logic [63:0]     ks_data;
    logic            ks_last;

    csa_stream_ctrl #(.PIPE_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .ck_valid(ck_valid), .ck(ck),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last),
        .sa_init(sa_init), .sa_sb(sa_sb), .sa_state(sa_state),
        .so_state(so_state), .so_cb(so_cb),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_last(ks_last)
    );

    always #5 clk = ~clk;

    // Stub pipeline: L-cycle delay line on sa_state
    logic [ST_W-1:0] pipe_q [L];
    always @(posedge clk) begin
        pipe_q[0] <= sa_state;
        for (int i = 1; i < L; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign so_state = pipe_q[L-1] + ST_W'(1);
    assign so_cb    = pipe_q[L-1][63:0] ^ CB_MASK;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;
    logic hold_ks = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s at cycle %0d: timed out, expected event did not occur", name, cyc);
    endtask

    // Reference model, written from the behavioural rules
    typedef struct { int cyc; logic init; logic [63:0] sb; logic [ST_W-1:0] st; } sa_exp_t;
    typedef struct { int cyc; logic [63:0] data; logic last; } ks_exp_t;

    sa_exp_t sa_q[$];
    ks_exp_t ks_q[$];
    sa_exp_t sa_cur;
    ks_exp_t ks_cur;
    logic ks_cur_on;
    logic [ST_W-1:0] m_key, m_saved;
    logic m_loaded, m_active, m_busy;

    function automatic logic [ST_W-1:0] ref_key(input logic [63:0] k);
        return {8'h00, k[31:0], 8'h00, k[63:32], 24'h0, 3'b000};
    endfunction

    task automatic model_reset();
        m_loaded = 1'b0; m_active = 1'b0; m_busy = 1'b0;
        m_key = '0; m_saved = '0;
        sa_q.delete(); ks_q.delete();
        sa_cur.cyc = 0; sa_cur.init = 1'b0; sa_cur.sb = '0; sa_cur.st = '0;
        ks_cur.cyc = 0; ks_cur.data = '0; ks_cur.last = 1'b0;
        ks_cur_on = 1'b0;
    endtask

    // Monitor: compare every output each cycle, then advance the model across the coming edge
    always @(negedge clk) begin
        logic idle_now;
        logic [ST_W-1:0] st;
        int g;
        sa_exp_t se;
        ks_exp_t ke;

        if (sa_q.size() > 0 && sa_q[0].cyc == cyc) sa_cur = sa_q.pop_front();
        if (ks_q.size() > 0 && ks_q[0].cyc == cyc) begin
            ks_cur = ks_q.pop_front();
            ks_cur_on = 1'b1;
        end

        check("blk_ready", 128'(blk_ready), 128'(rst_n && !m_busy && m_loaded && !ck_valid));
        check("sa_init",   128'(sa_init),   128'(sa_cur.init));
        check("sa_sb",     128'(sa_sb),     128'(sa_cur.sb));
        check("sa_state",  128'(sa_state),  128'(sa_cur.st));
        check("ks_valid",  128'(ks_valid),  128'(ks_cur_on));
        check("ks_data",   128'(ks_data),   128'(ks_cur.data));
        check("ks_last",   128'(ks_last),   128'(ks_cur.last));

        idle_now = !m_busy;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (ks_cur_on && ks_ready) begin
                ks_cur_on = 1'b0;
                m_busy = 1'b0;
                if (ks_cur.last) m_active = 1'b0;
            end
            if (idle_now && ck_valid) begin
                m_key = ref_key(ck);
                m_loaded = 1'b1;
                m_active = 1'b0;
            end else if (idle_now && m_loaded && blk_valid) begin
                st = m_saved;
                if (blk_first || !m_active) begin
                    se.cyc = cyc + 1; se.init = 1'b1; se.sb = blk_data; se.st = m_key;
                    sa_q.push_back(se);
                    st = m_key + ST_W'(1);
                    g = cyc + 2 + L;
                end else begin
                    g = cyc + 1;
                end
                se.cyc = g; se.init = 1'b0; se.sb = '0; se.st = st;
                sa_q.push_back(se);
                ke.cyc = g + L + 1; ke.data = st[63:0] ^ CB_MASK; ke.last = blk_last;
                ks_q.push_back(ke);
                m_saved = st + ST_W'(1);
                m_active = 1'b1;
                m_busy = 1'b1;
            end
        end
    end

    // Downstream acceptance, random unless held off
    initial begin
        ks_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ks_ready = hold_ks ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        ck        = {$urandom, $urandom};
        blk_data  = {$urandom, $urandom};
        blk_first = 1'($urandom);
        blk_last  = 1'($urandom);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst_n = 1'b0;
            ck_valid = 1'($urandom);
            blk_valid = 1'($urandom);
            rand_inputs();
            tick();
        end
        rst_n = 1'b1;
        ck_valid = 1'b0;
        blk_valid = 1'b0;
    endtask

    task automatic load_key(input logic [63:0] k);
        ck = k;
        ck_valid = 1'b1;
        tick();
        ck_valid = 1'b0;
        ck = {$urandom, $urandom};
    endtask

    task automatic send_block(input logic [63:0] d, input logic f, input logic l);
        logic ok;
        ok = 1'b0;
        blk_valid = 1'b1; blk_data = d; blk_first = f; blk_last = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (blk_ready) ok = 1'b1;
            tick();
        end
        blk_valid = 1'b0;
        rand_inputs();
        if (!ok) fail_now("blk_handshake");
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (m_busy && n < 300) begin
            tick();
            n++;
        end
        if (m_busy) fail_now("ks_handshake");
    endtask

    initial begin
        rst_n = 1'b0;
        ck_valid = 1'b0;
        blk_valid = 1'b0;
        rand_inputs();
        model_reset();

        do_reset(3);
        // No key yet: an offered block must not be taken
        blk_valid = 1'b1;
        repeat (4) tick();
        blk_valid = 1'b0;

        // Key load and block offered together: key wins
        ck = 64'h0123456789ABCDEF;
        ck_valid = 1'b1;
        blk_valid = 1'b1;
        tick();
        ck_valid = 1'b0;
        blk_valid = 1'b0;

        send_block(64'h1122334455667788, 1'b1, 1'b0);
        @(negedge clk);
        check("first_sa_init", 128'(sa_init), 128'(1'b1));
        check("first_sa_A", 128'(sa_state[A_LSB +: 40]), 128'(40'h0089ABCDEF));
        check("first_sa_B", 128'(sa_state[B_LSB +: 40]), 128'(40'h0001234567));
        check("first_sa_sb", 128'(sa_sb), 128'(64'h1122334455667788));
        wait_done();

        // Continuation block: generation pass only
        send_block(64'hCAFEF00DDEADBEEF, 1'b0, 1'b0);
        wait_done();

        // Backpressure on the keystream output, last block of the packet
        hold_ks = 1'b1;
        send_block(64'h0F0E0D0C0B0A0908, 1'b0, 1'b1);
        for (int i = 0; i < 100 && !ks_valid; i++) tick();
        repeat (5) tick();
        hold_ks = 1'b0;
        wait_done();

        // Packet closed: a non-first block restarts from the key
        send_block(64'h5555AAAA5555AAAA, 1'b0, 1'b0);
        wait_done();

        // Randomized traffic with occasional key reloads (ignored unless idle)
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) load_key({$urandom, $urandom});
            send_block({$urandom, $urandom}, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        wait_done();

        // Reset in the middle of a generation pass
        send_block({$urandom, $urandom}, 1'b1, 1'b0);
        wait_done();
        send_block({$urandom, $urandom}, 1'b0, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        blk_valid = 1'b1;
        repeat (5) tick();
        blk_valid = 1'b0;
        load_key(64'hFEDCBA9876543210);
        send_block({$urandom, $urandom}, 1'b0, 1'b1);
        wait_done();
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/csa_stream_ctrl.md
Name: csa_stream_ctrl

Overview:
Sequencer that sits directly upstream of the 8-byte stream-cipher pipeline (stream_8bytes) in the CSA descrambler. It loads the common key into the initial stream state and accepts 8-byte scrambled blocks. It drives the pipeline through an init pass (first block of a packet) followed by a generation pass. It feeds the resulting state back for later blocks of the same packet and emits one 64-bit keystream word per block.
Because each block depends on the previous state, only one block per packet is in flight at a time.

Parameters:
PIPE_LAT, 10, fixed cycles from driving sa_* to valid so_state/so_cb; must match the integrated pipeline.
ST_W, 107, packed state width {A[39:0],B[39:0],D,E,F,X,Y,Z[3:0] each,p,q,r}.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ck_valid  in  1  common-key load strobe
ck  in  64  common key
blk_valid  in  1  scrambled block offered
blk_ready  out  1  block accepted when blk_valid&&blk_ready
blk_data  in  64  scrambled block (byte0 = bits 7:0)
blk_first  in  1  first block of packet
blk_last  in  1  last block of packet
sa_init  out  1  init flag to pipeline
sa_sb  out  64  sb bytes to pipeline
sa_state  out  ST_W  state to pipeline
so_state  in  ST_W  state returned by pipeline
so_cb  in  64  keystream returned by pipeline
ks_valid  out  1  keystream word valid
ks_ready  in  1  downstream accepts keystream
ks_data  out  64  keystream word
ks_last  out  1  copy of blk_last for this word

Behaviour:
- Reset: all outputs 0, key_loaded=0, active=0, FSM in IDLE. A reset mid-operation aborts any block, with no ks output.
- Key mapping: key_state = {8'h00, ck[31:0], 8'h00, ck[63:32], 24'h0, 3'b000}. A and B nibble 0 is the LSB; all other registers are 0.
- ck_valid is sampled only in IDLE. It captures key_state, sets key_loaded=1 and clears active. It is ignored in other states.
- blk_ready = (state==IDLE) && key_loaded. If ck_valid and blk_valid arrive in the same IDLE cycle, the key load wins and blk_ready is forced to 0 that cycle.
- FSM states: IDLE, INIT_RUN, GEN_RUN, OUT.
- IDLE, on accept in cycle T: latch blk_last.
  - If blk_first || !active: go to INIT_RUN at T+1.
  - Otherwise: go to GEN_RUN at T+1.
- INIT_RUN:
  - Entry cycle drives sa_init=1, sa_sb=blk_data, sa_state=key_state.
  - sa_* are held until exit.
  - A down-counter samples so_state exactly PIPE_LAT cycles after entry.
  - Go to GEN_RUN next cycle. so_cb from this pass is discarded.
- GEN_RUN:
  - Entry drives sa_init=0, sa_sb=0, sa_state=saved state; these are held.
  - so_state and so_cb are sampled PIPE_LAT cycles after entry.
  - so_state goes to the saved state, so_cb to ks_data. Set active=1 and go to OUT.
- OUT: ks_valid=1; ks_data and ks_last are held stable until ks_ready.
  - On handshake: go to IDLE; if ks_last, clear active.
  - ks_valid deasserts the cycle after the handshake.
- Latency:
  - First block: ks_valid at T+3+2*PIPE_LAT (T+23 at default).
  - Subsequent block: ks_valid at T+2+PIPE_LAT (T+12).
- Outside their issue states, sa_init=0 and sa_sb/sa_state hold their last value.
- The counter width is clog2(PIPE_LAT+1). PIPE_LAT=0 is illegal; flag it with an elaboration assertion.

Decomposition:
- csa_pkg holds ST_W, the field offsets of the packed state, and a key_to_state function.
- The latency counter and FSM stay in this module. No sub-module is needed.
- A pack/unpack shim to the discrete stream_8bytes ports lives at the integration level.

Test Plan:
- Reset: drive rst_n=0 for 3 cycles with random inputs -> all outputs 0, blk_ready=0. blk_ready stays 0 until ck_valid.
- Key load plus first block, using a stub pipeline (delay PIPE_LAT=10, state+1, cb=state[63:0]^64'hA5A5...):
  - Stimulus: ck=64'h0123456789ABCDEF, blk_data=64'h1122334455667788 accepted at T.
  - T+1: sa_init=1, sa_sb=blk_data, sa_A=40'h0089ABCDEF, sa_B=40'h0001234567.
  - T+12: sa_init=0, sa_sb=0, sa_state=key_state+1.
  - T+23: ks_valid=1 with the expected ks_data.
- Second block with blk_first=0 accepted at U -> GEN_RUN only, ks_valid at U+12, sa_state equal to the previously captured state.
- Backpressure: hold ks_ready=0 for 5 cycles -> ks_data and ks_valid stable, blk_ready=0, no new sa_* issue. Release -> IDLE the next cycle.
- blk_last=1 handshake, then a block with blk_first=0 -> treated as first: INIT_RUN pass, sa_state=key_state.
- Reset asserted mid-GEN_RUN -> all outputs 0 the next cycle and key_loaded=0. A block offered afterwards is not accepted until a new ck_valid.
